ub_write_arbiter: RTL and testbench

- Burst-level arbiter for the unified buffer write port. Two requesters share it: the host/DMA load path and the accumulator writeback path.
- Grants whole bursts round-robin and generates the per-beat write strobe, address and data-mux select.
- Sits between the requesters and the unified buffer `write_i` / `unified_buffer_addr_wr` inputs. The data mux stays outside, driven by `ub_sel_o`.

---
 rtl/ub_write_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ub_write_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_write_arbiter.sv
// ub_write_arbiter
//
// Burst-level arbiter for the unified buffer write port. The host/DMA load
// path and the accumulator writeback path each request whole bursts. Bursts
// are granted round-robin. While a burst runs, this block produces the
// per-beat write strobe and address, plus the select for the external data mux.
//
// Ports:
//   clk_i, rstN_i            clock, asynchronous active-low reset
//   host_req_i/acc_req_i     burst request, held through the burst
//   host_addr_i/acc_addr_i   burst start address, sampled at grant
//   host_len_i/acc_len_i     beat count, sampled at grant (0 = 2^LEN_W beats)
//   host_valid_i/acc_valid_i beat data valid
//   host_gnt_o/acc_gnt_o     one-cycle pulse when the burst is accepted
//   host_ready_o/acc_ready_o high while that requester owns the port
//   host_done_o/acc_done_o   one-cycle pulse with the final beat
//   abort_o                  one-cycle pulse when the owner drops req mid-burst
//   ub_write_o               unified buffer write enable (same cycle as beat)
//   ub_addr_wr_o             unified buffer write address
//   ub_sel_o                 data mux select, 0 host / 1 accumulator
module ub_write_arbiter #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 8
) (
    input  logic              clk_i,
    input  logic              rstN_i,
    input  logic              host_req_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [LEN_W-1:0]  host_len_i,
    input  logic              host_valid_i,
    output logic              host_gnt_o,
    output logic              host_ready_o,
    output logic              host_done_o,
    input  logic              acc_req_i,
    input  logic [ADDR_W-1:0] acc_addr_i,
    input  logic [LEN_W-1:0]  acc_len_i,
    input  logic              acc_valid_i,
    output logic              acc_gnt_o,
    output logic              acc_ready_o,
    output logic              acc_done_o,
    output logic              abort_o,
    output logic              ub_write_o,
    output logic [ADDR_W-1:0] ub_addr_wr_o,
    output logic              ub_sel_o
);

    // ST_GAP is an idle cycle that follows a completed burst and never grants.
    // It enforces the single dead cycle between a final beat and the next grant.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    localparam logic OWNER_HOST = 1'b0;
    localparam logic OWNER_ACC  = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W:0]    remaining_q, remaining_d;

    logic              grant_valid;
    logic              grant_who;
    logic [LEN_W-1:0]  grant_len;
    logic [ADDR_W-1:0] grant_addr;
    logic              owner_req;
    logic              owner_valid;
    logic              beat;
    logic              last_beat;

    // Arbitration: a single requester wins outright. Under contention, the
    // winner is the side that did not own the previous burst. Gating with
    // rstN_i keeps the grant pulses low while reset is asserted.
    always_comb begin
        grant_valid = 1'b0;
        grant_who   = OWNER_HOST;
        if ((state_q == ST_IDLE) && rstN_i) begin
            if (host_req_i && acc_req_i) begin
                grant_valid = 1'b1;
                grant_who   = ~last_owner_q;
            end else if (host_req_i) begin
                grant_valid = 1'b1;
                grant_who   = OWNER_HOST;
            end else if (acc_req_i) begin
                grant_valid = 1'b1;
                grant_who   = OWNER_ACC;
            end
        end
    end

    assign grant_len   = (grant_who == OWNER_ACC) ? acc_len_i : host_len_i;
    assign grant_addr  = (grant_who == OWNER_ACC) ? acc_addr_i : host_addr_i;
    assign owner_req   = (owner_q == OWNER_ACC) ? acc_req_i : host_req_i;
    assign owner_valid = (owner_q == OWNER_ACC) ? acc_valid_i : host_valid_i;
    assign beat        = (state_q == ST_BURST) && owner_valid;
    assign last_beat   = beat && (remaining_q == (LEN_W+1)'(1));

    always_ff @(posedge clk_i or negedge rstN_i) begin
        if (!rstN_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_HOST;
            last_owner_q <= OWNER_ACC;
            addr_q       <= '0;
            remaining_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
        end
    end

    // A length of zero is widened to 2^LEN_W through the extra remaining bit.
    // An abort returns directly to ST_IDLE. No beat happens in the abort cycle,
    // so the dead cycle before the next grant is already present.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_BURST;
                    owner_d = grant_who;
                    addr_d  = grant_addr;
                    if (grant_len == '0) begin
                        remaining_d = {1'b1, {LEN_W{1'b0}}};
                    end else begin
                        remaining_d = {1'b0, grant_len};
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            ST_BURST: begin
                if (beat) begin
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - (LEN_W+1)'(1);
                    if (last_beat) begin
                        state_d      = ST_GAP;
                        last_owner_d = owner_q;
                    end
                end else if (!owner_req) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        host_gnt_o   = 1'b0;
        acc_gnt_o    = 1'b0;
        host_ready_o = 1'b0;
        acc_ready_o  = 1'b0;
        host_done_o  = 1'b0;
        acc_done_o   = 1'b0;
        abort_o      = 1'b0;
        ub_write_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                host_gnt_o = grant_valid && (grant_who == OWNER_HOST);
                acc_gnt_o  = grant_valid && (grant_who == OWNER_ACC);
            end
            ST_BURST: begin
                host_ready_o = (owner_q == OWNER_HOST);
                acc_ready_o  = (owner_q == OWNER_ACC);
                ub_write_o   = beat;
                host_done_o  = last_beat && (owner_q == OWNER_HOST);
                acc_done_o   = last_beat && (owner_q == OWNER_ACC);
                abort_o      = !beat && !owner_req;
            end
            default: begin
            end
        endcase
    end

    // Address and select come straight from registers, so they hold their
    // last values while idle.
    assign ub_addr_wr_o = addr_q;
    assign ub_sel_o     = owner_q;

endmodule

// File: tb/tb_ub_write_arbiter.sv
// tb_ub_write_arbiter
//
// Two requester agents work through queues of burst jobs. Each job has an
// address, a length, a valid pattern and an optional abort point. A
// transaction-level model of the arbiter predicts every output on every
// cycle. Directed scenarios also compare against hand-computed write
// addresses, grant orders and timing.
module tb_ub_write_arbiter;

    localparam int ADDR_W = 12;
    localparam int LEN_W  = 8;

    typedef struct {
        int addr;
        int len;
        int mode;
        int abort_after;
    } job_t;

    logic              clk_i  = 1'b0;
    logic              rstN_i = 1'b0;
    logic              req   [2];
    logic              valid [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [LEN_W-1:0]  len   [2];
    logic              host_gnt_o, host_ready_o, host_done_o;
    logic              acc_gnt_o, acc_ready_o, acc_done_o;
    logic              abort_o, ub_write_o, ub_sel_o;
    logic [ADDR_W-1:0] ub_addr_wr_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    job_t jobs_h[$];
    job_t jobs_a[$];
    int   ag_state [2];
    int   ag_beats [2];
    logic ag_tog   [2];
    job_t ag_job   [2];
    logic              n_req   [2];
    logic              n_valid [2];
    logic [ADDR_W-1:0] n_addr  [2];
    logic [LEN_W-1:0]  n_len   [2];

    int m_owner = -1;
    int m_left  = 0;
    int m_addr  = 0;
    int m_last  = 1;
    int m_cool  = 0;

    int wr_addr_q[$];
    int wr_cyc_q[$];
    int wr_sel_q[$];
    int gnt_side_q[$];
    int gnt_cyc_q[$];
    int done_cnt[2];
    int done_cyc;
    int abort_cnt;

    ub_write_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk_i        (clk_i),
        .rstN_i       (rstN_i),
        .host_req_i   (req[0]),
        .host_addr_i  (addr[0]),
        .host_len_i   (len[0]),
        .host_valid_i (valid[0]),
        .host_gnt_o   (host_gnt_o),
        .host_ready_o (host_ready_o),
        .host_done_o  (host_done_o),
        .acc_req_i    (req[1]),
        .acc_addr_i   (addr[1]),
        .acc_len_i    (len[1]),
        .acc_valid_i  (valid[1]),
        .acc_gnt_o    (acc_gnt_o),
        .acc_ready_o  (acc_ready_o),
        .acc_done_o   (acc_done_o),
        .abort_o      (abort_o),
        .ub_write_o   (ub_write_o),
        .ub_addr_wr_o (ub_addr_wr_o),
        .ub_sel_o     (ub_sel_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int pending(input int s);
        return (s == 0) ? jobs_h.size() : jobs_a.size();
    endfunction

    function automatic job_t front(input int s);
        return (s == 0) ? jobs_h[0] : jobs_a[0];
    endfunction

    task automatic popJob(input int s);
        if (s == 0) jobs_h.delete(0);
        else        jobs_a.delete(0);
    endtask

    // mode 0: valid always high, 1: alternate starting high, 2: random
    function automatic logic pickValid(input int s);
        logic v;
        case (ag_job[s].mode)
            0:       v = 1'b1;
            1:       begin v = ag_tog[s]; ag_tog[s] = ~ag_tog[s]; end
            default: v = ($urandom_range(0, 3) != 0);
        endcase
        return v;
    endfunction

    task automatic applyStimulus(input int s, input int a, input int l, input int mode, input int abort_after);
        job_t j;
        j.addr = a;
        j.len = l;
        j.mode = mode;
        j.abort_after = abort_after;
        if (s == 0) jobs_h.push_back(j);
        else        jobs_a.push_back(j);
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkWrites(input string tag, input int exp_addr[$], input int exp_sel);
        checkValue({tag, "_count"}, wr_addr_q.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < wr_addr_q.size(); i++) begin
            checkValue($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_addr[i]);
            if (exp_sel >= 0) checkValue($sformatf("%s_sel%0d", tag, i), wr_sel_q[i], exp_sel);
        end
    endtask

    task automatic clearLog();
        wr_addr_q.delete();
        wr_cyc_q.delete();
        wr_sel_q.delete();
        gnt_side_q.delete();
        gnt_cyc_q.delete();
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        done_cyc = -1;
        abort_cnt = 0;
    endtask

    task automatic agentObserve(input int s);
        logic gnt, rdy, dn;
        gnt = (s == 0) ? host_gnt_o : acc_gnt_o;
        rdy = (s == 0) ? host_ready_o : acc_ready_o;
        dn  = (s == 0) ? host_done_o : acc_done_o;
        n_req[s]   = req[s];
        n_valid[s] = 1'b0;
        n_addr[s]  = addr[s];
        n_len[s]   = len[s];
        if (!rstN_i) begin
            if (ag_state[s] != 0 && pending(s) > 0) popJob(s);
            ag_state[s] = 0;
            n_req[s] = 1'b0;
            return;
        end
        case (ag_state[s])
            0: begin
                if (pending(s) > 0) begin
                    ag_job[s]   = front(s);
                    n_req[s]    = 1'b1;
                    n_addr[s]   = ADDR_W'(ag_job[s].addr);
                    n_len[s]    = LEN_W'(ag_job[s].len);
                    ag_state[s] = 1;
                end
            end
            1: begin
                if (gnt) begin
                    ag_state[s] = 2;
                    ag_beats[s] = 0;
                    ag_tog[s]   = 1'b1;
                    n_valid[s]  = pickValid(s);
                end
            end
            default: begin
                if (ub_write_o && rdy) ag_beats[s]++;
                if (dn || (abort_o && rdy)) begin
                    popJob(s);
                    ag_state[s] = 0;
                    n_req[s] = 1'b0;
                end else if (!req[s]) begin
                    n_valid[s] = 1'b0;
                end else if (ag_job[s].abort_after > 0 && ag_beats[s] == ag_job[s].abort_after) begin
                    n_req[s] = 1'b0;
                end else begin
                    n_valid[s] = pickValid(s);
                end
            end
        endcase
    endtask

    // Requester agents: observe outputs at negedge, drive inputs after posedge.
    initial begin
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0;
            valid[s] = 1'b0;
            addr[s] = '0;
            len[s] = '0;
            ag_state[s] = 0;
            ag_beats[s] = 0;
            ag_tog[s] = 1'b0;
        end
        forever begin
            @(negedge clk_i);
            for (int s = 0; s < 2; s++) agentObserve(s);
            @(posedge clk_i);
            #1;
            for (int s = 0; s < 2; s++) begin
                req[s] = n_req[s];
                valid[s] = n_valid[s];
                addr[s] = n_addr[s];
                len[s] = n_len[s];
            end
        end
    end

    // Transaction-level model: who owns the port, how many beats are left,
    // which address comes next, and whether a post-burst dead cycle is due.
    task automatic checkOutput();
        logic [7:0] e_vec, a_vec;
        int e_addr, e_sel, w;
        e_vec = '0;
        e_addr = -1;
        e_sel = -1;
        if (!rstN_i) begin
            m_owner = -1;
            m_last = 1;
            m_cool = 0;
            e_addr = 0;
            e_sel = 0;
        end else if (m_owner < 0) begin
            if (m_cool != 0) begin
                m_cool = 0;
            end else if (req[0] || req[1]) begin
                w = (req[0] && req[1]) ? 1 - m_last : (req[0] ? 0 : 1);
                e_vec[7-w] = 1'b1;
                m_owner = w;
                m_left = (len[w] == 0) ? (1 << LEN_W) : int'(len[w]);
                m_addr = int'(addr[w]);
            end
        end else begin
            e_vec[5-m_owner] = 1'b1;
            if (valid[m_owner]) begin
                e_vec[0] = 1'b1;
                e_addr = m_addr;
                e_sel = m_owner;
                m_addr = (m_addr + 1) % (1 << ADDR_W);
                m_left--;
                if (m_left == 0) begin
                    e_vec[3-m_owner] = 1'b1;
                    m_last = m_owner;
                    m_owner = -1;
                    m_cool = 1;
                end
            end else if (!req[m_owner]) begin
                e_vec[1] = 1'b1;
                m_last = m_owner;
                m_owner = -1;
            end
        end
        a_vec = {host_gnt_o, acc_gnt_o, host_ready_o, acc_ready_o,
                 host_done_o, acc_done_o, abort_o, ub_write_o};
        vectors++;
        if ((a_vec !== e_vec) || (e_addr >= 0 && int'(ub_addr_wr_o) != e_addr) ||
            (e_sel >= 0 && int'(ub_sel_o) != e_sel)) begin
            miscompares++;
            $display("[TB] FAIL cycle_check @%0d: got gnt/rdy/done/abort/wr=%b addr=%0h sel=%0b, required %b addr=%0h sel=%0d",
                     cyc, a_vec, ub_addr_wr_o, ub_sel_o, e_vec, e_addr, e_sel);
        end
        if (rstN_i) begin
            if (ub_write_o) begin
                wr_addr_q.push_back(int'(ub_addr_wr_o));
                wr_cyc_q.push_back(cyc);
                wr_sel_q.push_back(int'(ub_sel_o));
            end
            if (host_gnt_o) begin gnt_side_q.push_back(0); gnt_cyc_q.push_back(cyc); end
            if (acc_gnt_o)  begin gnt_side_q.push_back(1); gnt_cyc_q.push_back(cyc); end
            if (host_done_o) begin done_cnt[0]++; done_cyc = cyc; end
            if (acc_done_o)  begin done_cnt[1]++; done_cyc = cyc; end
            if (abort_o) abort_cnt++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            cyc++;
            checkOutput();
        end
    end

    task automatic waitQuiet(input int max_cycles);
        int n;
        n = 0;
        while ((pending(0) + pending(1) > 0 || ag_state[0] != 0 || ag_state[1] != 0) && n < max_cycles) begin
            @(posedge clk_i);
            n++;
        end
        if (n >= max_cycles) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL wait_quiet: still busy after %0d cycles, required idle", n);
        end
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic doReset();
        @(posedge clk_i);
        #1;
        rstN_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checkValue("reset_write", int'(ub_write_o), 0);
        checkValue("reset_addr", int'(ub_addr_wr_o), 0);
        checkValue("reset_sel", int'(ub_sel_o), 0);
        rstN_i = 1'b1;
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_q[$];
        int n;
        clearLog();
        doReset();

        // Single host burst of 4 beats starting at 0x010.
        clearLog();
        applyStimulus(0, 'h010, 4, 0, 0);
        waitQuiet(100);
        exp_q = '{'h010, 'h011, 'h012, 'h013};
        checkWrites("t1", exp_q, 0);
        checkValue("t1_done_count", done_cnt[0], 1);
        if (wr_cyc_q.size() == 4 && gnt_cyc_q.size() == 1) begin
            checkValue("t1_gnt_to_first_write", wr_cyc_q[0] - gnt_cyc_q[0], 1);
            checkValue("t1_back_to_back", wr_cyc_q[3] - wr_cyc_q[0], 3);
            checkValue("t1_done_with_last", done_cyc, wr_cyc_q[3]);
        end

        // Contention straight after reset: host, then acc, then host again.
        doReset();
        clearLog();
        applyStimulus(0, 'h100, 2, 0, 0);
        applyStimulus(1, 'h200, 2, 0, 0);
        applyStimulus(0, 'h300, 1, 0, 0);
        waitQuiet(100);
        exp_q = '{'h100, 'h101, 'h200, 'h201, 'h300};
        checkWrites("t2", exp_q, -1);
        checkValue("t2_gnt_count", gnt_side_q.size(), 3);
        if (gnt_side_q.size() == 3 && wr_cyc_q.size() >= 2) begin
            checkValue("t2_gnt0", gnt_side_q[0], 0);
            checkValue("t2_gnt1", gnt_side_q[1], 1);
            checkValue("t2_gnt2", gnt_side_q[2], 0);
            checkValue("t2_acc_gnt_gap", gnt_cyc_q[1] - wr_cyc_q[1], 2);
        end

        // Accumulator burst wrapping through the top of the address space.
        clearLog();
        applyStimulus(1, 'hFFE, 4, 0, 0);
        waitQuiet(100);
        exp_q = '{'hFFE, 'hFFF, 'h000, 'h001};
        checkWrites("t3", exp_q, 1);
        checkValue("t3_done_count", done_cnt[1], 1);

        // Length zero means 256 beats.
        clearLog();
        applyStimulus(0, 'h400, 0, 0, 0);
        waitQuiet(400);
        checkValue("t4_count", wr_addr_q.size(), 256);
        if (wr_addr_q.size() == 256) begin
            checkValue("t4_first", wr_addr_q[0], 'h400);
            checkValue("t4_last", wr_addr_q[255], 'h4FF);
        end
        checkValue("t4_done_count", done_cnt[0], 1);

        // Toggling valid: writes only on valid cycles, addresses still consecutive.
        clearLog();
        applyStimulus(0, 'h020, 3, 1, 0);
        waitQuiet(100);
        exp_q = '{'h020, 'h021, 'h022};
        checkWrites("t5", exp_q, 0);
        if (wr_cyc_q.size() == 3) begin
            checkValue("t5_spacing1", wr_cyc_q[1] - wr_cyc_q[0], 2);
            checkValue("t5_spacing2", wr_cyc_q[2] - wr_cyc_q[1], 2);
            checkValue("t5_done_with_last", done_cyc, wr_cyc_q[2]);
        end

        // Acc aborts after 2 of 5 beats while a host request waits.
        clearLog();
        applyStimulus(1, 'h050, 5, 0, 2);
        applyStimulus(0, 'h060, 1, 0, 0);
        waitQuiet(100);
        exp_q = '{'h050, 'h051, 'h060};
        checkWrites("t6", exp_q, -1);
        checkValue("t6_abort_count", abort_cnt, 1);
        checkValue("t6_acc_done_count", done_cnt[1], 0);
        checkValue("t6_gnt_count", gnt_side_q.size(), 2);
        if (gnt_side_q.size() == 2 && wr_cyc_q.size() >= 2) begin
            checkValue("t6_gnt0", gnt_side_q[0], 1);
            checkValue("t6_gnt1", gnt_side_q[1], 0);
            checkValue("t6_host_gnt_after_abort", gnt_cyc_q[1] - wr_cyc_q[1], 2);
        end

        // Reset in the middle of a burst, then a fresh host burst.
        clearLog();
        applyStimulus(0, 'h070, 8, 0, 0);
        n = 0;
        while (wr_addr_q.size() < 3 && n < 50) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        checkValue("t7_reached_mid_burst", int'(wr_addr_q.size() >= 3), 1);
        rstN_i = 1'b0;
        #1;
        checkValue("t7_rst_write", int'(ub_write_o), 0);
        checkValue("t7_rst_ready", int'({host_ready_o, acc_ready_o}), 0);
        checkValue("t7_rst_gnt_done", int'({host_gnt_o, acc_gnt_o, host_done_o, acc_done_o}), 0);
        repeat (2) @(posedge clk_i);
        #1;
        rstN_i = 1'b1;
        waitQuiet(100);
        checkValue("t7_no_done", done_cnt[0], 0);
        clearLog();
        applyStimulus(0, 'h080, 2, 0, 0);
        waitQuiet(100);
        exp_q = '{'h080, 'h081};
        checkWrites("t7", exp_q, 0);

        // Randomized traffic from both sides.
        for (int i = 0; i < 25; i++) begin
            for (int s = 0; s < 2; s++) begin
                applyStimulus(s, int'($urandom_range(0, (1 << ADDR_W) - 1)),
                              ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 6)),
                              int'($urandom_range(0, 2)),
                              ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
        end
        waitQuiet(40000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
